frame_ram_arbiter: RTL and testbench
====================================

# frame_ram_arbiter

Arbitrates the single-port 640x480x12-bit frame RAM between three requesters: the VGA display reader, the static-process engine (read/write), and the image loader (write-only). It sits between those blocks and the RAM primitive. It issues one registered RAM command per cycle and returns read data to the originating requester with a valid strobe. Display has fixed priority, bounded by a starvation guard; process and loader share the remaining slots round-robin.

## Interface
- ADDR_W, 19, pixel address width
- DATA_W, 12, RGB444 pixel width
- RD_LAT, 1, RAM read latency in cycles (1..3)
- STARVE_MAX, 8, consecutive denied cycles before a low-priority requester preempts display
- FRAME_PIXELS, 307200, number of valid addresses
---
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- disp_req  in  1  display read request; held until granted
- disp_addr  in  ADDR_W  display read address
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  disp_rdata valid
- disp_rdata  out  DATA_W  read data for display
- proc_req  in  1  process request
- proc_we  in  1  1 = write, 0 = read
- proc_addr  in  ADDR_W  process address
- proc_wdata  in  DATA_W  process write data
- proc_gnt  out  1  process request accepted
- proc_rvalid  out  1  proc_rdata valid
- proc_rdata  out  DATA_W  read data for process
- load_req  in  1  loader write request
- load_addr  in  ADDR_W  loader address
- load_wdata  in  DATA_W  loader write data
- load_gnt  out  1  loader request accepted
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data
- oob_err  out  1  sticky: an out-of-range address was granted

## Operation
- Grant decision is combinational from the current requests. At most one `*_gnt` is high per cycle, and a grant implies the matching request is high.
- Priority:
  - If a starvation flag is set, that requester wins over display.
  - Otherwise display wins if it requests.
  - Otherwise proc and load are served round-robin by `last_srv`. After reset, `last_srv` = load, so proc wins the first tie.
- Starvation counters, one each for proc and load:
  - Increment while the request is high and not granted.
  - Clear on grant or when the request drops.
  - Saturate at STARVE_MAX. The flag is set when the counter equals STARVE_MAX.
  - If both flags are set, round-robin decides between proc and load.
- Loader requests are always writes. Display requests are always reads.
- Out-of-range address (addr >= FRAME_PIXELS):
  - The request is still granted.
  - The RAM command is issued with ram_en=0.
  - A read returns rdata=0 with rvalid asserted on the normal schedule.
  - oob_err is set and held until reset.
- Read-return tagging: a tag pipe of depth 1+RD_LAT carries {valid, requester id, oob}. At the output it drives exactly one rvalid for one cycle. Writes produce no rvalid.
- Requesters may change address or data in the cycle after a grant. Back-to-back grants to the same requester are allowed.

## Timing
- Grant in cycle T drives the registered RAM command (ram_en, ram_we, ram_addr, ram_din) in cycle T+1.
- Read data is sampled from ram_dout in cycle T+1+RD_LAT. rdata/rvalid for that read are asserted in that same cycle, passed through from ram_dout (0 when the oob bit is set).
- Throughput: one access per cycle. No idle cycles between consecutive grants.
- Reset (asynchronous assert, synchronous release):
  - All outputs go to 0.
  - Tag pipe valids are cleared, so no spurious rvalid after release.
  - Counters are 0. `last_srv` = load.
- Reset mid-transaction: in-flight reads are discarded without rvalid, and the requester re-issues.
- A request dropped before grant is simply withdrawn. Nothing is latched.

## Structure
- Shared package `frame_ram_pkg`:
  - ADDR_W, DATA_W, FRAME_PIXELS
  - requester id enum: REQ_DISP=0, REQ_PROC=1, REQ_LOAD=2
  - tag struct {valid, id, oob}
- Sub-module `ram_rd_tag_pipe`: parameterized-depth shift register of tags with reset-cleared valids.
- Top level contains the arbiter, starvation counters, command register, and return demux.

## Test plan
- Display only: continuous disp_req on addresses 0..9 with RD_LAT=1. Required: disp_gnt every cycle; disp_rdata equals preloaded RAM content, arriving 2 cycles after each grant, in order.
- Proc and load both requesting continuously, no display. Required: grants alternate proc, load, proc, … starting with proc; each load write is visible in the RAM model at the next cycle.
- Display and proc continuously requesting. Required: proc granted exactly once every STARVE_MAX+1 = 9 cycles; display gets the other 8.
- Proc reads address 307200. Required: ram_en=0 in the command cycle; proc_rvalid with proc_rdata=0 two cycles after grant; oob_err=1 and held.
- Assert rst low one cycle after a disp_req grant. Required: no disp_rvalid before or after release; all outputs 0 during reset; proc wins the first proc/load tie after release.
- Proc write then read of address 640 on consecutive grants. Required: the read returns the just-written proc_wdata.

Source files
------------

// File: rtl/frame_ram_pkg.sv
// Shared types and frame geometry for the frame RAM arbiter and its tag pipe.
package frame_ram_pkg;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 12;
  localparam int FRAME_PIXELS = 307200;

  typedef enum logic [1:0] {
    REQ_DISP = 2'd0,
    REQ_PROC = 2'd1,
    REQ_LOAD = 2'd2
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    oob;
  } rd_tag_t;

  function automatic logic addr_oob(input logic [ADDR_W-1:0] addr);
    return addr >= ADDR_W'(FRAME_PIXELS);
  endfunction

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// Shift register that carries read tags alongside the RAM read latency so
// returning data can be routed to its requester.
module ram_rd_tag_pipe
  import frame_ram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [DEPTH];

  // Clearing whole tags on reset discards in-flight reads without a strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/frame_ram_arbiter.sv
// Arbitrates the single-port frame RAM among display, process and loader,
// issuing one registered RAM command per cycle and routing read data back.
module frame_ram_arbiter
  import frame_ram_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_gnt_o,
  output logic              disp_rvalid_o,
  output logic [DATA_W-1:0] disp_rdata_o,
  input  logic              proc_req_i,
  input  logic              proc_we_i,
  input  logic [ADDR_W-1:0] proc_addr_i,
  input  logic [DATA_W-1:0] proc_wdata_i,
  output logic              proc_gnt_o,
  output logic              proc_rvalid_o,
  output logic [DATA_W-1:0] proc_rdata_o,
  input  logic              load_req_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_wdata_i,
  output logic              load_gnt_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic              oob_err_o
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  proc_cnt_q, proc_cnt_d, load_cnt_q, load_cnt_d;
  req_id_e           last_srv_q, last_srv_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              oob_err_q, oob_err_d;

  logic              proc_starve, load_starve, rr_proc;
  logic              sel_any, sel_wr, sel_oob;
  req_id_e           sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  rd_tag_t           tag_in, tag_out;
  logic [DATA_W-1:0] ret_data;

  assign proc_starve = proc_req_i && (proc_cnt_q == CNT_MAX);
  assign load_starve = load_req_i && (load_cnt_q == CNT_MAX);
  assign rr_proc     = (last_srv_q == REQ_LOAD);

  // Starved requesters beat display; proc/load ties go round-robin.
  always_comb begin
    disp_gnt_o = 1'b0;
    proc_gnt_o = 1'b0;
    load_gnt_o = 1'b0;
    if (rst_ni) begin
      if (proc_starve && load_starve) begin
        proc_gnt_o = rr_proc;
        load_gnt_o = !rr_proc;
      end else if (proc_starve || load_starve) begin
        proc_gnt_o = proc_starve;
        load_gnt_o = load_starve;
      end else if (disp_req_i) begin
        disp_gnt_o = 1'b1;
      end else if (proc_req_i && load_req_i) begin
        proc_gnt_o = rr_proc;
        load_gnt_o = !rr_proc;
      end else begin
        proc_gnt_o = proc_req_i;
        load_gnt_o = load_req_i;
      end
    end
  end

  always_comb begin
    sel_any  = disp_gnt_o | proc_gnt_o | load_gnt_o;
    sel_id   = REQ_DISP;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    if (disp_gnt_o) begin
      sel_addr = disp_addr_i;
    end else if (proc_gnt_o) begin
      sel_id   = REQ_PROC;
      sel_wr   = proc_we_i;
      sel_addr = proc_addr_i;
      sel_din  = proc_we_i ? proc_wdata_i : '0;
    end else if (load_gnt_o) begin
      sel_id   = REQ_LOAD;
      sel_wr   = 1'b1;
      sel_addr = load_addr_i;
      sel_din  = load_wdata_i;
    end
    // Out-of-range accesses are granted but never reach the RAM.
    sel_oob    = sel_any && addr_oob(sel_addr);
    ram_en_d   = sel_any && !sel_oob;
    ram_we_d   = ram_en_d && sel_wr;
    ram_addr_d = sel_addr;
    ram_din_d  = sel_din;
    tag_in     = '{valid: sel_any && !sel_wr, id: sel_id, oob: sel_oob};
  end

  always_comb begin
    proc_cnt_d = '0;
    load_cnt_d = '0;
    if (proc_req_i && !proc_gnt_o)
      proc_cnt_d = (proc_cnt_q == CNT_MAX) ? CNT_MAX : proc_cnt_q + 1'b1;
    if (load_req_i && !load_gnt_o)
      load_cnt_d = (load_cnt_q == CNT_MAX) ? CNT_MAX : load_cnt_q + 1'b1;
    last_srv_d = last_srv_q;
    if (proc_gnt_o)      last_srv_d = REQ_PROC;
    else if (load_gnt_o) last_srv_d = REQ_LOAD;
    oob_err_d = oob_err_q | sel_oob;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proc_cnt_q <= '0;
      load_cnt_q <= '0;
      last_srv_q <= REQ_LOAD;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      oob_err_q  <= 1'b0;
    end else begin
      proc_cnt_q <= proc_cnt_d;
      load_cnt_q <= load_cnt_d;
      last_srv_q <= last_srv_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      oob_err_q  <= oob_err_d;
    end
  end

  ram_rd_tag_pipe #(.DEPTH(1 + RD_LAT)) u_tag_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );

  assign ram_en_o   = ram_en_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign oob_err_o  = oob_err_q;

  assign ret_data      = tag_out.oob ? '0 : ram_dout_i;
  assign disp_rvalid_o = tag_out.valid && (tag_out.id == REQ_DISP);
  assign proc_rvalid_o = tag_out.valid && (tag_out.id == REQ_PROC);
  assign disp_rdata_o  = disp_rvalid_o ? ret_data : '0;
  assign proc_rdata_o  = proc_rvalid_o ? ret_data : '0;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed and random checks of frame_ram_arbiter against a priority and
// memory reference model, with a one-cycle-latency RAM model attached.
module tb_frame_ram_arbiter;
  import frame_ram_pkg::*;

  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic              dispReq = 1'b0, procReq = 1'b0, procWe = 1'b0, loadReq = 1'b0;
  logic [ADDR_W-1:0] dispAddr = '0, procAddr = '0, loadAddr = '0;
  logic [DATA_W-1:0] procWdata = '0, loadWdata = '0;
  logic              dispGnt, dispRvalid, procGnt, procRvalid, loadGnt;
  logic [DATA_W-1:0] dispRdata, procRdata;
  logic              ramEn, ramWe, oobErr;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramDin;
  logic [DATA_W-1:0] ramDout = '0;

  always #5 clk = ~clk;

  frame_ram_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .disp_req_i(dispReq), .disp_addr_i(dispAddr), .disp_gnt_o(dispGnt),
    .disp_rvalid_o(dispRvalid), .disp_rdata_o(dispRdata),
    .proc_req_i(procReq), .proc_we_i(procWe), .proc_addr_i(procAddr),
    .proc_wdata_i(procWdata), .proc_gnt_o(procGnt), .proc_rvalid_o(procRvalid),
    .proc_rdata_o(procRdata),
    .load_req_i(loadReq), .load_addr_i(loadAddr), .load_wdata_i(loadWdata),
    .load_gnt_o(loadGnt),
    .ram_en_o(ramEn), .ram_we_o(ramWe), .ram_addr_o(ramAddr), .ram_din_o(ramDin),
    .ram_dout_i(ramDout), .oob_err_o(oobErr)
  );

  logic [DATA_W-1:0] ramArr [FRAME_PIXELS];
  logic [DATA_W-1:0] refMem [FRAME_PIXELS];

  always @(posedge clk) begin
    if (ramEn) begin
      if (ramWe) ramArr[ramAddr] <= ramDin;
      else       ramDout <= ramArr[ramAddr];
    end
  end

  typedef struct {
    int                due;
    int                who;
    logic [DATA_W-1:0] data;
  } retItem_t;

  int                errors = 0;
  int                checks = 0;
  int                cycleNo = 0;
  int                waitProc, waitLoad, lastServed;
  bit                oobSeen;
  retItem_t          retQ[$];
  bit                cmdEnExp, cmdWeExp;
  logic [ADDR_W-1:0] cmdAddrExp;
  logic [DATA_W-1:0] cmdDinExp;
  int                dutGrants[4];
  int                procRetCount;
  int                base1, base2, base3;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cycleNo);
    end
  endtask

  task automatic resetModel();
    retQ.delete();
    waitProc   = 0;
    waitLoad   = 0;
    lastServed = 3;
    oobSeen    = 1'b0;
    cmdEnExp   = 1'b0;
    cmdWeExp   = 1'b0;
    cmdAddrExp = '0;
    cmdDinExp  = '0;
  endtask

  // Winner codes: 0 none, 1 display, 2 process, 3 loader.
  function automatic int tieBreak(bit p, bit l);
    if (p && l) return (lastServed == 3) ? 2 : 3;
    if (p) return 2;
    if (l) return 3;
    return 0;
  endfunction

  function automatic int expectedWinner();
    bit pStarve;
    bit lStarve;
    pStarve = procReq && (waitProc >= STARVE_MAX);
    lStarve = loadReq && (waitLoad >= STARVE_MAX);
    if (!rstN) return 0;
    if (pStarve || lStarve) return tieBreak(pStarve, lStarve);
    if (dispReq) return 1;
    return tieBreak(procReq, loadReq);
  endfunction

  function automatic int bump(int w, bit req, int me);
    if (req && (w != me)) return ((w == me) ? 0 : 1);
    return 0;
  endfunction

  // One clock: check DUT against the model, then advance the model past the edge.
  task automatic runCycle();
    int                w;
    bit                isWr;
    bit                oob;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                expDispV, expProcV;
    logic [DATA_W-1:0] expData;
    retItem_t          item;
    #1;
    if (!rstN) resetModel();
    w = expectedWinner();
    checkOutput("disp_gnt", dispGnt, w == 1);
    checkOutput("proc_gnt", procGnt, w == 2);
    checkOutput("load_gnt", loadGnt, w == 3);
    checkOutput("ram_en", ramEn, cmdEnExp);
    checkOutput("ram_we", ramWe, cmdWeExp);
    if (cmdEnExp) checkOutput("ram_addr", ramAddr, cmdAddrExp);
    if (cmdWeExp) checkOutput("ram_din", ramDin, cmdDinExp);
    if (!rstN) begin
      checkOutput("rst_ram_addr", ramAddr, 0);
      checkOutput("rst_ram_din", ramDin, 0);
    end
    expDispV = 1'b0;
    expProcV = 1'b0;
    expData  = '0;
    if (retQ.size() > 0 && retQ[0].due == cycleNo) begin
      item     = retQ.pop_front();
      expDispV = (item.who == 1);
      expProcV = (item.who == 2);
      expData  = item.data;
    end
    checkOutput("disp_rvalid", dispRvalid, expDispV);
    checkOutput("proc_rvalid", procRvalid, expProcV);
    checkOutput("disp_rdata", dispRdata, expDispV ? expData : '0);
    checkOutput("proc_rdata", procRdata, expProcV ? expData : '0);
    checkOutput("oob_err", oobErr, oobSeen);
    dutGrants[1] += int'(dispGnt);
    dutGrants[2] += int'(procGnt);
    dutGrants[3] += int'(loadGnt);
    procRetCount += int'(procRvalid);
    @(posedge clk);
    if (rstN) begin
      waitProc = (procReq && w != 2) ? ((waitProc + 1 > STARVE_MAX) ? STARVE_MAX : waitProc + 1) : 0;
      waitLoad = (loadReq && w != 3) ? ((waitLoad + 1 > STARVE_MAX) ? STARVE_MAX : waitLoad + 1) : 0;
      if (w == 2) lastServed = 2;
      if (w == 3) lastServed = 3;
      cmdEnExp = 1'b0;
      cmdWeExp = 1'b0;
      if (w != 0) begin
        a    = (w == 1) ? dispAddr : (w == 2) ? procAddr : loadAddr;
        isWr = (w == 3) || (w == 2 && procWe);
        d    = (w == 3) ? loadWdata : procWdata;
        oob  = (a >= FRAME_PIXELS);
        if (oob) oobSeen = 1'b1;
        cmdEnExp   = !oob;
        cmdWeExp   = isWr && !oob;
        cmdAddrExp = a;
        cmdDinExp  = d;
        if (isWr && !oob) refMem[a] = d;
        if (!isWr) begin
          item.due  = cycleNo + 1 + RD_LAT;
          item.who  = w;
          item.data = oob ? '0 : refMem[a];
          retQ.push_back(item);
        end
      end
    end
    cycleNo++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit dR, input logic [ADDR_W-1:0] dA,
                               input bit pR, input bit pW, input logic [ADDR_W-1:0] pA,
                               input logic [DATA_W-1:0] pD, input bit lR,
                               input logic [ADDR_W-1:0] lA, input logic [DATA_W-1:0] lD);
    dispReq = dR; dispAddr = dA;
    procReq = pR; procWe = pW; procAddr = pA; procWdata = pD;
    loadReq = lR; loadAddr = lA; loadWdata = lD;
    runCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, '0, '0, 0, '0, '0);
  endtask

  function automatic logic [ADDR_W-1:0] randAddr();
    if ($urandom_range(0, 15) == 0) return ADDR_W'(FRAME_PIXELS + $urandom_range(0, 5000));
    return ADDR_W'($urandom_range(0, 63));
  endfunction

  initial begin
    for (int i = 0; i < FRAME_PIXELS; i++) begin
      ramArr[i] = DATA_W'(i * 37 + 5);
      refMem[i] = DATA_W'(i * 37 + 5);
    end
    for (int i = 0; i < 4; i++) dutGrants[i] = 0;
    procRetCount = 0;
    resetModel();
    @(negedge clk);

    // Reset state with every request raised.
    applyStimulus(1, 19'd3, 1, 0, 19'd4, 12'h111, 1, 19'd5, 12'h222);
    applyStimulus(1, 19'd3, 1, 0, 19'd4, 12'h111, 1, 19'd5, 12'h222);
    rstN = 1'b1;
    idle(1);

    $display("[TB] display-only stream");
    base1 = dutGrants[1];
    for (int i = 0; i < 10; i++) applyStimulus(1, ADDR_W'(i), 0, 0, '0, '0, 0, '0, '0);
    idle(3);
    checkOutput("disp_only_grants", dutGrants[1] - base1, 10);

    $display("[TB] process/loader round-robin");
    base2 = dutGrants[2];
    base3 = dutGrants[3];
    for (int i = 0; i < 10; i++)
      applyStimulus(0, '0, 1, 1, ADDR_W'(100 + i), DATA_W'(12'h500 + i),
                    1, ADDR_W'(200 + i), DATA_W'(12'h700 + i));
    idle(2);
    checkOutput("rr_proc_grants", dutGrants[2] - base2, 5);
    checkOutput("rr_load_grants", dutGrants[3] - base3, 5);

    $display("[TB] display versus process starvation");
    base1 = dutGrants[1];
    base2 = dutGrants[2];
    for (int i = 0; i < 27; i++)
      applyStimulus(1, ADDR_W'(i), 1, 0, ADDR_W'(300 + i), '0, 0, '0, '0);
    idle(3);
    checkOutput("starve_proc_grants", dutGrants[2] - base2, 3);
    checkOutput("starve_disp_grants", dutGrants[1] - base1, 24);

    $display("[TB] out-of-range read");
    applyStimulus(0, '0, 1, 0, ADDR_W'(FRAME_PIXELS), '0, 0, '0, '0);
    idle(3);
    checkOutput("oob_sticky", oobErr, 1);

    $display("[TB] write then read of 640");
    base2 = procRetCount;
    applyStimulus(0, '0, 1, 1, 19'd640, 12'hABC, 0, '0, '0);
    applyStimulus(0, '0, 1, 0, 19'd640, 12'h000, 0, '0, '0);
    idle(3);
    checkOutput("raw_return_count", procRetCount - base2, 1);

    $display("[TB] reset during display read");
    applyStimulus(1, 19'd5, 0, 0, '0, '0, 0, '0, '0);
    rstN = 1'b0;
    applyStimulus(1, 19'd6, 1, 0, 19'd7, '0, 1, 19'd8, 12'h333);
    applyStimulus(1, 19'd6, 1, 0, 19'd7, '0, 1, 19'd8, 12'h333);
    rstN = 1'b1;
    base2 = dutGrants[2];
    applyStimulus(0, '0, 1, 0, 19'd9, '0, 1, 19'd10, 12'h444);
    checkOutput("post_reset_proc_first", dutGrants[2] - base2, 1);
    idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 99) < 60, randAddr(),
                    $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), randAddr(),
                    DATA_W'($urandom), $urandom_range(0, 99) < 50, randAddr(),
                    DATA_W'($urandom));
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
